ram_sync_ctrl: RTL and testbench

Parametrised synchronous successor to the 64x8 asynchronous RAM: a DEPTH x WIDTH single-port memory with the same active-low _ce/_we/_oe bus. All bus inputs are sampled on the rising clock edge, and read data is registered. A built-in clear sequencer zeroes every word after reset or on request, and flags when the array is usable. It sits between the bus-side test/CPU logic and the storage array.

---
 rtl/ram_sync_ctrl_if.sv | 40 ++++
 rtl/ram_sync_ctrl.sv | 137 +++++++++++++
 tb/tb_ram_sync_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ram_sync_ctrl_if.sv
// Bus bundle for ram_sync_ctrl: active-low _ce/_we/_oe/_clr controls, address/data and status.
// The parity pins (inj_perr, perr) exist only when RAM_SYNC_CTRL_PARITY_EN is defined.
interface ram_sync_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
);
  logic [AW-1:0]    adrs;
  logic [WIDTH-1:0] dataIn;
  logic             _ce;
  logic             _we;
  logic             _oe;
  logic             _clr;
  logic [WIDTH-1:0] dataOut;
  logic             rd_valid;
  logic             ready;
  logic             oor;
`ifdef RAM_SYNC_CTRL_PARITY_EN
  logic             inj_perr;
  logic             perr;

  modport master (
    output adrs, dataIn, _ce, _we, _oe, _clr, inj_perr,
    input  dataOut, rd_valid, ready, oor, perr
  );
  modport slave (
    input  adrs, dataIn, _ce, _we, _oe, _clr, inj_perr,
    output dataOut, rd_valid, ready, oor, perr
  );
`else
  modport master (
    output adrs, dataIn, _ce, _we, _oe, _clr,
    input  dataOut, rd_valid, ready, oor
  );
  modport slave (
    input  adrs, dataIn, _ce, _we, _oe, _clr,
    output dataOut, rd_valid, ready, oor
  );
`endif
endinterface

// File: rtl/ram_sync_ctrl.sv
// Synchronous DEPTH x WIDTH single-port RAM with registered read data and a clear sequencer.
// Optional per-word even parity with error reporting when RAM_SYNC_CTRL_PARITY_EN is defined.
module ram_sync_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input logic            clk,
  input logic            _rst,
  ram_sync_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef RAM_SYNC_CTRL_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_L  = AW'(DEPTH - 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_valid_q, rd_valid_d;
  logic             oor_q, oor_d;
  logic             perr_q, perr_d;

  logic [MW-1:0]    mem_q [DEPTH];
  logic             mem_we_s;
  logic [AW-1:0]    mem_addr_s;
  logic [MW-1:0]    mem_wdata_s;
  logic [MW-1:0]    mem_rdata_s;
  logic             in_range_s;
  logic             wr_s;
  logic             rd_s;

  function automatic logic even_par_f(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Words at or beyond DEPTH exist in the address space only when DEPTH is not a power of two
  assign in_range_s  = ({1'b0, bus.adrs} < DEPTH_L);
  assign wr_s        = !bus._ce && !bus._we;
  assign rd_s        = !bus._ce && bus._we && !bus._oe;
  assign mem_rdata_s = in_range_s ? mem_q[bus.adrs] : {MW{1'b0}};

  // Next-state, memory write port and output register decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    rd_valid_d  = 1'b0;
    oor_d       = 1'b0;
    perr_d      = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = cnt_q;
    mem_wdata_s = {MW{1'b0}};
    case (state_q)
      INIT: begin
        mem_we_s = 1'b1;
        if (cnt_q == LAST_L) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + AW'(1'b1);
        end
      end
      RUN: begin
        if (!bus._clr) begin
          state_d = INIT;
          cnt_d   = {AW{1'b0}};
        end else if (wr_s) begin
          mem_addr_s = bus.adrs;
          mem_we_s   = in_range_s;
          oor_d      = !in_range_s;
`ifdef RAM_SYNC_CTRL_PARITY_EN
          mem_wdata_s = {even_par_f(bus.dataIn) ^ bus.inj_perr, bus.dataIn};
`else
          mem_wdata_s = bus.dataIn;
`endif
        end else if (rd_s) begin
          dout_d     = mem_rdata_s[WIDTH-1:0];
          rd_valid_d = 1'b1;
          oor_d      = !in_range_s;
`ifdef RAM_SYNC_CTRL_PARITY_EN
          perr_d     = in_range_s && (even_par_f(mem_rdata_s[WIDTH-1:0]) != mem_rdata_s[WIDTH]);
`else
          perr_d     = 1'b0;
`endif
        end else begin
          dout_d = dout_q;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q    <= INIT;
      cnt_q      <= {AW{1'b0}};
      dout_q     <= {WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      oor_q      <= oor_d;
      perr_q     <= perr_d;
    end
  end

  // Storage array; contents are rebuilt by INIT rather than reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign bus.dataOut  = dout_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.oor      = oor_q;
  assign bus.ready    = (state_q == RUN);
`ifdef RAM_SYNC_CTRL_PARITY_EN
  assign bus.perr     = perr_q;
`else
  logic unused_perr_s;
  assign unused_perr_s = perr_q;
`endif
endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Scoreboard bench for ram_sync_ctrl: a DEPTH=64 instance and a DEPTH=48 instance for out-of-range cases.
module tb_ram_sync_ctrl;
  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  ram_sync_ctrl_if #(.WIDTH(8), .DEPTH(64)) bus_a ();
  ram_sync_ctrl_if #(.WIDTH(8), .DEPTH(48)) bus_b ();

  ram_sync_ctrl #(.WIDTH(8), .DEPTH(64)) u_dut_a (.clk(clk), ._rst(rst_n), .bus(bus_a));
  ram_sync_ctrl #(.WIDTH(8), .DEPTH(48)) u_dut_b (.clk(clk), ._rst(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on the selected bus (b=1 selects the 48-word part); the other bus idles
  task automatic acc(input bit b, input logic ce, input logic we, input logic oe,
                     input logic [5:0] a, input logic [7:0] d);
    bus_a._ce = b ? 1'b1 : ce;
    bus_a._we = b ? 1'b1 : we;
    bus_a._oe = b ? 1'b1 : oe;
    bus_b._ce = b ? ce : 1'b1;
    bus_b._we = b ? we : 1'b1;
    bus_b._oe = b ? oe : 1'b1;
    bus_a.adrs = a;  bus_a.dataIn = d;
    bus_b.adrs = a;  bus_b.dataIn = d;
    @(negedge clk);
  endtask

  task automatic wr(input bit b, input logic [5:0] a, input logic [7:0] d);
    acc(b, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input bit b, input logic [5:0] a, input logic [7:0] e);
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
    acc(b, 1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) acc(1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 8'h00);
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest outstanding expected read
  always @(negedge clk) begin
    if (bus_a.rd_valid) begin
      if (q_a.size() == 0) check_eq("a_spurious_rd_valid", 32'd1, 32'd0);
      else check_eq("a_rdata", 32'(bus_a.dataOut), 32'(q_a.pop_front()));
    end
    if (bus_b.rd_valid) begin
      if (q_b.size() == 0) check_eq("b_spurious_rd_valid", 32'd1, 32'd0);
      else check_eq("b_rdata", 32'(bus_b.dataOut), 32'(q_b.pop_front()));
    end
  end

  initial begin
    int n;
    int na;
    int nb;
    rst_n = 1'b0;
    bus_a._clr = 1'b1;
    bus_b._clr = 1'b1;
`ifdef RAM_SYNC_CTRL_PARITY_EN
    bus_a.inj_perr = 1'b0;
    bus_b.inj_perr = 1'b0;
`endif
    idle(3);
    check_eq("rst_ready", 32'(bus_a.ready), 32'd0);
    check_eq("rst_dataOut", 32'(bus_a.dataOut), 32'd0);
    check_eq("rst_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check_eq("rst_oor", 32'(bus_a.oor), 32'd0);

    rst_n = 1'b1;
    n = 0; na = 0; nb = 0;
    while ((!bus_a.ready || !bus_b.ready) && n < 200) begin
      @(negedge clk);
      n++;
      if (bus_a.ready && na == 0) na = n;
      if (bus_b.ready && nb == 0) nb = n;
    end
    check_eq("init_cycles_64", 32'(na), 32'd64);
    check_eq("init_cycles_48", 32'(nb), 32'd48);

    rd(1'b0, 6'h00, 8'h00);
    rd(1'b0, 6'h3F, 8'h00);
    check_eq("a_oor_inrange", 32'(bus_a.oor), 32'd0);

    wr(1'b0, 6'h00, 8'hFF);
    wr(1'b0, 6'h10, 8'hEE);
    wr(1'b0, 6'h20, 8'hDD);
    wr(1'b0, 6'h30, 8'hCC);
    rd(1'b0, 6'h00, 8'hFF);
    rd(1'b0, 6'h10, 8'hEE);
    rd(1'b0, 6'h20, 8'hDD);
    rd(1'b0, 6'h30, 8'hCC);

    wr(1'b0, 6'h3E, 8'h77);
    rd(1'b0, 6'h3E, 8'h77);

    acc(1'b0, 1'b0, 1'b0, 1'b0, 6'h10, 8'h55);
    check_eq("we_oe_no_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    rd(1'b0, 6'h10, 8'h55);
    idle(1);
    check_eq("idle_hold_dataOut", 32'(bus_a.dataOut), 32'h55);
    check_eq("idle_rd_valid", 32'(bus_a.rd_valid), 32'd0);

    wr(1'b1, 6'd47, 8'hAA);
    check_eq("b_oor_wr_inrange", 32'(bus_b.oor), 32'd0);
    wr(1'b1, 6'd50, 8'hBB);
    check_eq("b_oor_wr", 32'(bus_b.oor), 32'd1);
    idle(1);
    check_eq("b_oor_pulse_end", 32'(bus_b.oor), 32'd0);
    rd(1'b1, 6'd50, 8'h00);
    check_eq("b_oor_rd", 32'(bus_b.oor), 32'd1);
    rd(1'b1, 6'd47, 8'hAA);
    check_eq("b_oor_rd_inrange", 32'(bus_b.oor), 32'd0);

    bus_a._clr = 1'b0;
    acc(1'b0, 1'b0, 1'b1, 1'b0, 6'h10, 8'h00);
    bus_a._clr = 1'b1;
    check_eq("clr_ready_drop", 32'(bus_a.ready), 32'd0);
    n = 0;
    while (!bus_a.ready && n < 200) begin
      if (n < 3) acc(1'b0, 1'b0, 1'b1, 1'b0, 6'h10, 8'h00);
      else       idle(1);
      n++;
    end
    check_eq("clr_init_cycles", 32'(n), 32'd64);
    rd(1'b0, 6'h10, 8'h00);
    rd(1'b0, 6'h00, 8'h00);

`ifdef RAM_SYNC_CTRL_PARITY_EN
    bus_a.inj_perr = 1'b1;
    wr(1'b0, 6'h05, 8'h01);
    bus_a.inj_perr = 1'b0;
    rd(1'b0, 6'h05, 8'h01);
    check_eq("perr_injected", 32'(bus_a.perr), 32'd1);
    wr(1'b0, 6'h05, 8'h01);
    rd(1'b0, 6'h05, 8'h01);
    check_eq("perr_clean", 32'(bus_a.perr), 32'd0);
`endif

    idle(2);
    check_eq("a_queue_drained", 32'(q_a.size()), 32'd0);
    check_eq("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
